// File: rtl/pwm_bank.sv
// Double-buffered multi-channel PWM bank with optional per-channel phase stagger.
// Duty writes land in a shadow bank and reach the comparators only at a period wrap or while stopped.
module pwm_bank #(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned STAGGER    = 0,
    parameter int unsigned INVERT     = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_strobe,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  enable,
    output logic [CHANNELS-1:0]   outputs,
    output logic                  period_start
);

    localparam logic INV = (INVERT != 0);

    // Elaboration-time phase offset; the shift/divide folds to a constant per channel.
    function automatic logic [WIDTH-1:0] offset_of(input int unsigned idx);
        logic [63:0] span;
        span = (64'(idx) << WIDTH) / 64'(CHANNELS);
        return WIDTH'(span);
    endfunction

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic [WIDTH-1:0]    phase    [CHANNELS];
    logic [CHANNELS-1:0] outputs_q, outputs_d;
    logic                period_start_q, period_start_d;
    logic                load;

    always_comb begin
        // Strobe-only write port: accepted every cycle, no ready; last write to an address wins.
        load           = !enable || (cnt_q == '1);
        cnt_d          = enable ? cnt_q + 1'b1 : '0;
        period_start_d = enable && (cnt_q == '0);
        outputs_d      = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_strobe && (wr_address == ADDR_WIDTH'(i))) begin
                shadow_d[i] = wr_data;
            end
            // Pre-edge shadow is loaded, so a write coinciding with the wrap waits one period.
            active_d[i]  = load ? shadow_q[i] : active_q[i];
            phase[i]     = cnt_q + ((STAGGER != 0) ? offset_of(i) : '0);
            outputs_d[i] = (enable && (phase[i] < active_q[i])) ^ INV;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q          <= '0;
            outputs_q      <= {CHANNELS{INV}};
            period_start_q <= 1'b0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            cnt_q          <= cnt_d;
            outputs_q      <= outputs_d;
            period_start_q <= period_start_d;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign outputs      = outputs_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: one 4-channel inverted instance, one 3-channel staggered instance.
module tb_pwm_bank;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       a_wr = 1'b0;
    logic [1:0] a_addr = '0;
    logic [3:0] a_data = '0;
    logic       a_en = 1'b0;
    logic [3:0] a_out;
    logic       a_ps;

    logic       b_wr = 1'b0;
    logic [1:0] b_addr = '0;
    logic [3:0] b_data = '0;
    logic       b_en = 1'b0;
    logic [2:0] b_out;
    logic       b_ps;

    logic       sel = 1'b0;
    logic [3:0] obs_out;
    logic       obs_ps;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    pwm_bank #(.CHANNELS(4), .WIDTH(4), .ADDR_WIDTH(2), .STAGGER(0), .INVERT(1)) dut_a (
        .clock(clock), .reset(reset), .wr_strobe(a_wr), .wr_address(a_addr),
        .wr_data(a_data), .enable(a_en), .outputs(a_out), .period_start(a_ps)
    );

    pwm_bank #(.CHANNELS(3), .WIDTH(4), .ADDR_WIDTH(2), .STAGGER(1), .INVERT(0)) dut_b (
        .clock(clock), .reset(reset), .wr_strobe(b_wr), .wr_address(b_addr),
        .wr_data(b_data), .enable(b_en), .outputs(b_out), .period_start(b_ps)
    );

    // Logical (active-high) view of whichever instance is under test.
    assign obs_out = sel ? {1'b0, b_out} : ~a_out;
    assign obs_ps  = sel ? b_ps : a_ps;

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_a(input logic [1:0] addr, input logic [3:0] data);
        a_wr = 1'b1; a_addr = addr; a_data = data;
        tick();
        a_wr = 1'b0;
    endtask

    task automatic write_b(input logic [1:0] addr, input logic [3:0] data);
        b_wr = 1'b1; b_addr = addr; b_data = data;
        tick();
        b_wr = 1'b0;
    endtask

    task automatic wait_ps(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (obs_ps) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq({tag, "_ps_seen"}, found, 1'b1);
    endtask

    task automatic push4(input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
    endtask

    // Called in a period_start cycle; records 16 output cycles, returns in the last one.
    task automatic capture(input string tag);
        logic [15:0] pat [4];
        int ps_cnt;
        logic [15:0] want;
        ps_cnt = 0;
        for (int c = 0; c < 4; c++) pat[c] = '0;
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < 4; c++) pat[c][k] = obs_out[c];
            if (obs_ps) ps_cnt++;
            if (k < 15) tick();
        end
        check_eq({tag, "_ps_count"}, ps_cnt, 1);
        for (int c = 0; c < 4; c++) begin
            want = exp_q.pop_front();
            check_eq($sformatf("%s_ch%0d", tag, c), pat[c], want);
        end
    endtask

    initial begin
        logic held_bad;
        logic found;

        // Reset state
        #12;
        check_eq("rst_out_a", a_out, 4'hF);
        check_eq("rst_ps_a", a_ps, 1'b0);
        check_eq("rst_out_b", b_out, 3'h0);
        tick();
        reset = 1'b0;

        // Load ch0 while stopped, run, then reset mid-pulse
        write_a(2'd0, 4'd8);
        tick();
        a_en = 1'b1;
        tick();
        check_eq("en_first_ps", a_ps, 1'b1);
        tick();
        tick();
        check_eq("pre_rst_ch0", a_out[0], 1'b0);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_out", a_out, 4'hF);
        check_eq("async_rst_ps", a_ps, 1'b0);
        tick();
        reset = 1'b0;

        // Shadow lost: duty 0 everywhere, period_start every 16 cycles
        wait_ps("rst");
        push4(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        capture("rst");
        tick();
        check_eq("ps_period", a_ps, 1'b1);

        // Double-buffering: writes at cnt 7, 8, 9 hold off until the wrap
        repeat (6) tick();
        write_a(2'd1, 4'd5);
        write_a(2'd2, 4'd15);
        write_a(2'd3, 4'd2);
        held_bad = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (a_ps) begin
                found = 1'b1;
                break;
            end
            if (a_out != 4'hF) held_bad = 1'b1;
            tick();
        end
        check_eq("dbuf_ps_seen", found, 1'b1);
        check_eq("dbuf_hold", held_bad, 1'b0);
        push4(16'h0000, 16'h001F, 16'h7FFF, 16'h0003);
        capture("dbuf1");
        tick();
        push4(16'h0000, 16'h001F, 16'h7FFF, 16'h0003);
        capture("dbuf2");

        // Write ch3=6 in the cnt=15 cycle while active=2
        tick();
        repeat (14) tick();
        write_a(2'd3, 4'd6);
        tick();
        check_eq("wrap_ps", a_ps, 1'b1);
        push4(16'h0000, 16'h001F, 16'h7FFF, 16'h0003);
        capture("wrap1");
        tick();
        push4(16'h0000, 16'h001F, 16'h7FFF, 16'h003F);
        capture("wrap2");

        // Enable gating and write while stopped
        tick();
        tick();
        tick();
        check_eq("mid_pulse_ch3", a_out[3], 1'b0);
        a_en = 1'b0;
        tick();
        check_eq("dis_out", a_out, 4'hF);
        check_eq("dis_ps", a_ps, 1'b0);
        write_a(2'd0, 4'd9);
        tick();
        tick();
        a_en = 1'b1;
        tick();
        check_eq("reen_ps", a_ps, 1'b1);
        push4(16'h01FF, 16'h001F, 16'h7FFF, 16'h003F);
        capture("reen");

        // Staggered instance: out-of-range address, then equal duties
        sel = 1'b1;
        write_b(2'd3, 4'd15);
        tick();
        b_en = 1'b1;
        tick();
        check_eq("oor_ps", b_ps, 1'b1);
        push4(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        capture("oor");
        b_en = 1'b0;
        tick();
        write_b(2'd0, 4'd5);
        write_b(2'd1, 4'd5);
        write_b(2'd2, 4'd5);
        tick();
        b_en = 1'b1;
        tick();
        check_eq("stag_ps", b_ps, 1'b1);
        push4(16'h001F, 16'hF800, 16'h07C0, 16'h0000);
        capture("stag");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
# pwm_bank

Parametrised, double-buffered multi-channel PWM generator. It replaces the fixed 8×16-bit PWM stage behind the SPI daisy-chain reader. It takes the reader's address/data/strobe write port directly and owns its own duty registers. New duty values are buffered and only take effect at a period boundary, so there are no runt or glitch pulses. Optional phase staggering spreads channel turn-on edges across the period to reduce inrush.

## Interface
- CHANNELS, 8, number of PWM outputs (1..2^WIDTH)
- WIDTH, 16, counter/duty width; period = 2^WIDTH cycles
- ADDR_WIDTH, 3, write address width; 2^ADDR_WIDTH >= CHANNELS
- STAGGER, 0, 1 = channel i phase-offset by i·2^WIDTH/CHANNELS (truncated)
- INVERT, 0, 1 = all outputs inverted (active-low drivers)

Ports:
- clock  in  1  single clock domain
- reset  in  1  asynchronous, active-high
- wr_strobe  in  1  write duty register
- wr_address  in  ADDR_WIDTH  channel index
- wr_data  in  WIDTH  duty value
- enable  in  1  run PWM
- outputs  out  CHANNELS  PWM outputs, registered
- period_start  out  1  one-cycle pulse at first output cycle of each period

## Operation
- Counter `cnt` (WIDTH bits):
  - Increments by 1 per cycle while enable=1 and wraps from 2^WIDTH−1 to 0.
  - Cleared to 0 while enable=0.
- Shadow write:
  - On wr_strobe with wr_address < CHANNELS: shadow[wr_address] <= wr_data.
  - Addresses ≥ CHANNELS are ignored with no side effect.
- Active load:
  - All active[i] <= shadow[i] at the edge where cnt goes 2^WIDTH−1→0.
  - While enable=0, active loads from shadow every cycle, so stopped updates apply immediately.
- Simultaneous write and wrap in the same cycle:
  - active takes the pre-edge shadow value.
  - The new write applies at the next wrap.
- Phase: phase_i = (cnt + offset_i) mod 2^WIDTH.
  - offset_i = (i·2^WIDTH)/CHANNELS when STAGGER=1, else 0.
  - Constants only; no multiplier in hardware.
- Compare: raw_i = (phase_i < active_i), unsigned.
  - Duty 0 gives a constantly low output.
  - Duty 2^WIDTH−1 gives high for 2^WIDTH−1 of 2^WIDTH cycles; 100% is not reachable.
- outputs[i] <= (enable ? raw_i : 0) XOR INVERT.
- period_start <= enable && (cnt == 0).
- Reset values:
  - cnt=0, all shadow=0, all active=0.
  - outputs = {CHANNELS{INVERT}}, period_start=0.

## Timing
- Output latency: 1 cycle from cnt value to outputs/period_start.
- Period-boundary alignment:
  - period_start is high in the same cycle as the outputs for cnt=0.
  - Those outputs are computed from the newly loaded active values.
- Write latency while enabled: a write takes effect on the first output cycle after the next wrap.
  - Minimum 2 cycles (write when cnt=2^WIDTH−2).
  - Maximum 2^WIDTH+1 cycles (write when cnt=2^WIDTH−1).
- enable deasserted:
  - Next edge: outputs go inactive, period_start=0, cnt=0.
  - Re-assert: first period_start one edge later with cnt=0 compare; the full period restarts.
- Reset mid-period: all state returns to reset values immediately (asynchronous). Shadow contents are lost.
- No stalls or backpressure: wr_strobe is accepted every cycle, including back-to-back writes to the same address (last write wins).

## Test plan
- Reset (WIDTH=4, CHANNELS=4, INVERT=1):
  - Assert reset mid-run → outputs=4'b1111 and period_start=0 asynchronously.
  - After release with enable=1 → period_start every 16 cycles; all outputs stay 1 (duty 0).
- Double-buffering (WIDTH=4):
  - Write ch1=5 at cnt=7 → ch1 unchanged for the rest of the period.
  - From next period_start: high 5 cycles, low 11, repeating.
- Boundary duties: ch0=0 → never high; ch2=15 → high 15, low 1 per 16-cycle period.
- Write on wrap: write ch3=6 in the cycle cnt=15 while active=2 → next period is high 2 cycles; the period after is high 6 cycles.
- Out-of-range and stagger (CHANNELS=3, ADDR_WIDTH=2, WIDTH=4, STAGGER=1):
  - Write addr 3 → no channel changes.
  - All duties 5 with offsets 0,5,10 → high windows at cnt 0–4, 11–15, 6–10 (non-overlapping).
- Enable gating:
  - Drop enable mid-pulse → outputs inactive next edge.
  - Write ch0=9 while disabled, then re-enable → first period high exactly 9 cycles, starting with period_start.
